data_spm: RTL and testbench
===========================

Name: data_spm

Overview:
- Word-organised data scratchpad that sits directly downstream of the memory-access controller.
- Consumes the controller's address, store data, byte enables and read/write enables, and returns load data one cycle later; that load data feeds the controller's load-extension path.
- A second, lower-priority bus-slave port lets an external master (debug/DMA) read and write the same array.
- Bus starvation is bounded by a wait counter that forces a one-cycle CPU stall.

Parameters:
- DEPTH, 4096, number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH), word-index width.
- BASE_ADDR, 32'h0001_0000, byte base address; aligned to DEPTH*4.
- MAX_WAIT, 8, bus-pending cycles tolerated before the CPU is stalled; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  CPU-port stage valid
- cpu_we  in  1  store request
- cpu_rd  in  1  load request
- cpu_addr  in  32  byte address
- cpu_byteena  in  4  byte lanes for a store
- cpu_wdata  in  32  store data, lane-aligned
- cpu_rdata  out  32  load data, registered
- cpu_fault  out  1  out-of-range CPU access, registered pulse
- cpu_stall  out  1  CPU must hold its access this cycle
- bus_req  in  1  bus request, held until bus_gnt
- bus_we  in  1  bus write
- bus_addr  in  32  bus byte address
- bus_byteena  in  4  bus write lanes
- bus_wdata  in  32  bus write data
- bus_gnt  out  1  request accepted this cycle
- bus_rvalid  out  1  response valid, one-cycle pulse
- bus_rdata  out  32  bus read data
- bus_err  out  1  out-of-range bus access, qualified by bus_rvalid

Behaviour:
- Reset values: cpu_rdata=0, cpu_fault=0, cpu_stall=0, bus_gnt=0, bus_rvalid=0, bus_rdata=0, bus_err=0, FSM=IDLE, wait counter=0. Array contents are not reset.
- Range check: addr[31:AW+2]==BASE_ADDR[31:AW+2]. Word index = addr[AW+1:2]. addr[1:0] is ignored; misalignment is flagged upstream.
- CPU access: cpu_act = cpu_en && (cpu_we||cpu_rd) && !cpu_stall.
  - Store: bytes with byteena[i]=1 are written at the clock edge.
  - Load: array word is returned on cpu_rdata the next cycle.
  - Out of range: no write; cpu_rdata=0 and cpu_fault=1 the next cycle.
  - cpu_we and cpu_rd both high: treat as store.
- cpu_rdata holds its value until the next CPU load.
- Bus FSM:
  - IDLE: when bus_req=1 and the slot is free (!cpu_act), assert bus_gnt combinationally, perform the access in this cycle, go to RESP.
  - RESP: bus_rvalid=1 for exactly one cycle. For reads, bus_rdata = word; for writes, bus_rdata = 0. bus_err per range check. Return to IDLE. Back-to-back grants are therefore at most every 2 cycles.
- Starvation control:
  - Wait counter increments each cycle bus_req=1 with no grant (IDLE).
  - When counter==MAX_WAIT, assert cpu_stall for that one cycle, which forces the bus grant.
  - Counter clears on grant.
- cpu_stall never asserts outside that condition.
- Read-after-write across ports: a write at edge N is visible to either port's read issued in cycle N+1. Same-cycle CPU/bus conflicts cannot occur, by construction.
- rst asserted mid-transaction: FSM returns to IDLE; any in-flight response is dropped (no bus_rvalid); cpu_fault/cpu_rdata clear. A write whose edge coincides with reset assertion is undefined.

Decomposition:
- Shared package/define file holds:
  - WORD_WIDTH=32.
  - Bus FSM state encodings SPM_IDLE, SPM_RESP.
  - A BYTE_LANES=4 constant.
- One natural sub-module: spm_ram, a single-port byte-write synchronous RAM (DEPTH x 32, registered read, per-byte write enable), instantiated once. The top muxes the CPU or bus request onto it.

Test Plan:
- Store then load: CPU store 32'hDEADBEEF, byteena 4'b1111 @BASE+0x10, then load @BASE+0x10 -> cpu_rdata=32'hDEADBEEF one cycle after the load, cpu_fault=0.
- Partial store: byteena 4'b0010, data 32'h0000AA00 onto word 32'h11223344 -> subsequent load returns 32'h1122AA44.
- Out of range: CPU load @BASE+DEPTH*4 -> cpu_rdata=0, cpu_fault=1 for one cycle; array unchanged.
- Idle CPU: bus read @BASE+0x10 with CPU idle -> bus_gnt same cycle, bus_rvalid=1 with bus_rdata=32'hDEADBEEF next cycle, bus_err=0.
- Starvation: CPU loads every cycle, bus_req held, MAX_WAIT=8 -> cpu_stall=1 exactly on the 9th pending cycle with bus_gnt=1 in that cycle; stall deasserts next cycle.
- Reset mid-operation: assert rst in the RESP cycle after a bus grant -> bus_rvalid stays 0, all outputs 0; after release, a new bus_req is granted normally.

Source files
------------

// File: rtl/data_spm_pkg.sv
// Shared constants and bus FSM encoding for the data scratchpad.
package data_spm_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic {
    SPM_IDLE = 1'b0,
    SPM_RESP = 1'b1
  } spm_state_e;

endpackage

// File: rtl/data_spm_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module spm_ram
  import data_spm_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [BYTE_LANES-1:0] byteena,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // rdata only moves on a read, so it holds the last word read until the next one.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (byteena[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_spm.sv
// Data scratchpad: CPU port with priority, bus-slave port served in idle slots,
// and a wait counter that steals one CPU cycle when the bus has waited too long.
module data_spm
  import data_spm_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          MAX_WAIT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en,
  input  logic                  cpu_we,
  input  logic                  cpu_rd,
  input  logic [31:0]           cpu_addr,
  input  logic [BYTE_LANES-1:0] cpu_byteena,
  input  logic [WORD_WIDTH-1:0] cpu_wdata,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_fault,
  output logic                  cpu_stall,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [31:0]           bus_addr,
  input  logic [BYTE_LANES-1:0] bus_byteena,
  input  logic [WORD_WIDTH-1:0] bus_wdata,
  output logic                  bus_gnt,
  output logic                  bus_rvalid,
  output logic [WORD_WIDTH-1:0] bus_rdata,
  output logic                  bus_err
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  spm_state_e            state;
  logic [7:0]            wait_cnt;
  logic                  cpu_act;
  logic                  cpu_in_range;
  logic                  bus_in_range;
  logic                  cpu_load_q;
  logic [WORD_WIDTH-1:0] cpu_rdata_hold;
  logic                  bus_rd_q;

  logic                  ram_en;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [BYTE_LANES-1:0] ram_be;
  logic [WORD_WIDTH-1:0] ram_wdata;
  logic [WORD_WIDTH-1:0] ram_rdata;

  // The low address bits select a byte within a word; alignment is checked upstream.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{cpu_addr[1:0], bus_addr[1:0]};

  assign cpu_in_range = (cpu_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign bus_in_range = (bus_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

  // The stall only depends on registered state and bus_req, so cpu_act/bus_gnt form no loop.
  assign cpu_stall = (state == SPM_IDLE) && bus_req && (wait_cnt == MAX_WAIT_C);
  assign cpu_act   = cpu_en && (cpu_we || cpu_rd) && !cpu_stall;
  assign bus_gnt   = (state == SPM_IDLE) && bus_req && !cpu_act;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus_addr[AW+1:2];
    ram_be    = bus_byteena;
    ram_wdata = bus_wdata;
    if (cpu_act) begin
      ram_en    = cpu_in_range;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr[AW+1:2];
      ram_be    = cpu_byteena;
      ram_wdata = cpu_wdata;
    end else if (bus_gnt) begin
      ram_en = bus_in_range;
      ram_we = bus_we;
    end
  end

  spm_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .byteena (ram_be),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SPM_IDLE;
      wait_cnt   <= 8'd0;
      bus_rvalid <= 1'b0;
      bus_err    <= 1'b0;
      bus_rd_q   <= 1'b0;
    end else begin
      bus_rvalid <= bus_gnt;
      bus_err    <= bus_gnt && !bus_in_range;
      bus_rd_q   <= bus_gnt && !bus_we && bus_in_range;
      case (state)
        SPM_IDLE: begin
          if (bus_gnt) begin
            state    <= SPM_RESP;
            wait_cnt <= 8'd0;
          end else if (bus_req) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SPM_RESP: state <= SPM_IDLE;
        default:  state <= SPM_IDLE;
      endcase
    end
  end

  assign bus_rdata = bus_rd_q ? ram_rdata : '0;

  // A fault clears the held load data; otherwise the word just read is captured for holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_load_q     <= 1'b0;
      cpu_fault      <= 1'b0;
      cpu_rdata_hold <= '0;
    end else begin
      cpu_load_q <= cpu_act && cpu_in_range && !cpu_we;
      cpu_fault  <= cpu_act && !cpu_in_range;
      if (cpu_act && !cpu_in_range) begin
        cpu_rdata_hold <= '0;
      end else if (cpu_load_q) begin
        cpu_rdata_hold <= ram_rdata;
      end
    end
  end

  assign cpu_rdata = cpu_load_q ? ram_rdata : cpu_rdata_hold;

endmodule

// File: tb/tb_data_spm.sv
// Bench for data_spm: directed scenarios, then random CPU/bus traffic against a cycle-level model.
module tb_data_spm;

  localparam int          DEPTH    = 4096;
  localparam logic [31:0] BASE     = 32'h0001_0000;
  localparam logic [31:0] SPAN     = DEPTH * 4;
  localparam int          MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_we, cpu_rd;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteena;
  logic [31:0] cpu_rdata;
  logic        cpu_fault, cpu_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteena;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  data_spm #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_we      (cpu_we),
    .cpu_rd      (cpu_rd),
    .cpu_addr    (cpu_addr),
    .cpu_byteena (cpu_byteena),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_fault   (cpu_fault),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_byteena (bus_byteena),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cpu_rdata = '0;
  logic        m_cpu_fault = 1'b0;
  logic        m_rvalid    = 1'b0;
  logic [31:0] m_bus_rdata = '0;
  logic        m_bus_err   = 1'b0;
  logic        m_busy      = 1'b0;
  int          m_wait      = 0;
  logic        exp_gnt_last;
  logic        obs_gnt, obs_stall;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] lo;
    int unsigned r;
    lo = 32'($urandom_range(0, 3));
    r  = $urandom_range(0, 9);
    if (r < 8) return BASE + 32'(4 * $urandom_range(0, 15)) + lo;
    if (r == 8) return BASE + SPAN - 32'd4 + lo;
    case ($urandom_range(0, 2))
      0:       return BASE + SPAN + lo;
      1:       return BASE - 32'd4 + lo;
      default: return lo;
    endcase
  endfunction

  task automatic resetModel();
    m_cpu_rdata = '0;
    m_cpu_fault = 1'b0;
    m_rvalid    = 1'b0;
    m_bus_rdata = '0;
    m_bus_err   = 1'b0;
    m_busy      = 1'b0;
    m_wait      = 0;
  endtask

  // One clock cycle: drive, check against the model, advance the model, step past the edge.
  task automatic applyStimulus(
    input logic c_en, input logic c_we, input logic c_rd, input logic [31:0] c_addr,
    input logic [3:0] c_be, input logic [31:0] c_wd,
    input logic b_req, input logic b_we, input logic [31:0] b_addr,
    input logic [3:0] b_be, input logic [31:0] b_wd);
    logic stall_e, act, gnt_e;
    cpu_en = c_en; cpu_we = c_we; cpu_rd = c_rd; cpu_addr = c_addr;
    cpu_byteena = c_be; cpu_wdata = c_wd;
    bus_req = b_req; bus_we = b_we; bus_addr = b_addr;
    bus_byteena = b_be; bus_wdata = b_wd;
    #2;
    stall_e = !m_busy && b_req && (m_wait == MAX_WAIT);
    act     = c_en && (c_we || c_rd) && !stall_e;
    gnt_e   = !m_busy && b_req && !act;
    obs_gnt   = bus_gnt;
    obs_stall = cpu_stall;
    checkOutput("cpu_stall", 32'(cpu_stall), 32'(stall_e));
    checkOutput("bus_gnt", 32'(bus_gnt), 32'(gnt_e));
    checkOutput("cpu_rdata", cpu_rdata, m_cpu_rdata);
    checkOutput("cpu_fault", 32'(cpu_fault), 32'(m_cpu_fault));
    checkOutput("bus_rvalid", 32'(bus_rvalid), 32'(m_rvalid));
    if (m_rvalid) begin
      checkOutput("bus_rdata", bus_rdata, m_bus_rdata);
      checkOutput("bus_err", 32'(bus_err), 32'(m_bus_err));
    end
    m_rvalid    = gnt_e;
    m_bus_rdata = '0;
    m_bus_err   = 1'b0;
    if (gnt_e) begin
      m_bus_err = !in_rng(b_addr);
      if (in_rng(b_addr)) begin
        if (b_we) m_mem[word_of(b_addr)] = merge(m_mem[word_of(b_addr)], b_wd, b_be);
        else      m_bus_rdata = m_mem[word_of(b_addr)];
      end
    end
    m_cpu_fault = 1'b0;
    if (act) begin
      if (!in_rng(c_addr)) begin
        m_cpu_fault = 1'b1;
        m_cpu_rdata = '0;
      end else if (c_we) begin
        m_mem[word_of(c_addr)] = merge(m_mem[word_of(c_addr)], c_wd, c_be);
      end else begin
        m_cpu_rdata = m_mem[word_of(c_addr)];
      end
    end
    if (gnt_e) m_wait = 0;
    else if (!m_busy && b_req) m_wait++;
    m_busy = gnt_e;
    exp_gnt_last = gnt_e;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    checkOutput({tag, "_cpu_fault"}, 32'(cpu_fault), 32'h0);
    checkOutput({tag, "_cpu_stall"}, 32'(cpu_stall), 32'h0);
    checkOutput({tag, "_bus_gnt"}, 32'(bus_gnt), 32'h0);
    checkOutput({tag, "_bus_rvalid"}, 32'(bus_rvalid), 32'h0);
    checkOutput({tag, "_bus_rdata"}, bus_rdata, 32'h0);
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'h0);
  endtask

  initial begin
    int stall_cycle, gnt_cycle;
    logic        pb_valid, pb_we;
    logic [31:0] pb_addr, pb_wd;
    logic [3:0]  pb_be;
    logic        ce, cw, cr;

    rst = 1'b1;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_byteena = '0; cpu_wdata = '0;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_byteena = '0; bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] store then load");
    applyStimulus(1'b1, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("plan_load", cpu_rdata, 32'hDEADBEEF);
    checkOutput("plan_load_fault", 32'(cpu_fault), 32'h0);

    $display("[TB] partial store");
    applyStimulus(1'b1, 1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, BASE + 32'h20, 4'b0010, 32'h0000AA00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("plan_partial", cpu_rdata, 32'h1122AA44);

    $display("[TB] out of range");
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + SPAN, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("plan_oor_rdata", cpu_rdata, 32'h0);
    checkOutput("plan_oor_fault", 32'(cpu_fault), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, BASE + SPAN + 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    idleCycle();
    checkOutput("plan_oor_pulse", 32'(cpu_fault), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("plan_oor_unchanged", cpu_rdata, 32'hDEADBEEF);

    $display("[TB] bus read with idle cpu");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    checkOutput("plan_bus_gnt", 32'(obs_gnt), 32'h1);
    checkOutput("plan_bus_rvalid", 32'(bus_rvalid), 32'h1);
    checkOutput("plan_bus_rdata", bus_rdata, 32'hDEADBEEF);
    checkOutput("plan_bus_err", 32'(bus_err), 32'h0);
    idleCycle();

    $display("[TB] starvation");
    stall_cycle = 0;
    gnt_cycle   = 0;
    for (int k = 1; k <= 20 && gnt_cycle == 0; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
      if (obs_stall && stall_cycle == 0) stall_cycle = k;
      if (obs_gnt) gnt_cycle = k;
    end
    checkOutput("starve_stall_cycle", 32'(stall_cycle), 32'd9);
    checkOutput("starve_gnt_cycle", 32'(gnt_cycle), 32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("starve_release", 32'(obs_stall), 32'h0);
    idleCycle();

    $display("[TB] reset during response");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    bus_req = 1'b0;
    rst = 1'b1;
    #2;
    checkAllZero("midreset");
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    checkOutput("postreset_gnt", 32'(obs_gnt), 32'h1);
    checkOutput("postreset_rdata", bus_rdata, 32'h1122AA44);

    $display("[TB] random traffic");
    for (int w = 0; w < 16; w++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, BASE + 32'(4 * w), 4'hF, $urandom, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, BASE + SPAN - 32'd4, 4'hF, $urandom, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    pb_valid = 1'b0;
    pb_we    = 1'b0;
    pb_addr  = '0;
    pb_be    = '0;
    pb_wd    = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pb_valid && $urandom_range(0, 2) == 0) begin
        pb_valid = 1'b1;
        pb_we    = 1'($urandom_range(0, 1));
        pb_addr  = pick_addr();
        pb_be    = 4'($urandom);
        pb_wd    = $urandom;
      end
      if (((n / 200) % 2) == 1) begin
        ce = 1'b1;
        cw = 1'b0;
        cr = 1'b1;
      end else begin
        ce = ($urandom_range(0, 9) < 8);
        cw = ($urandom_range(0, 2) == 0);
        cr = 1'($urandom_range(0, 1));
      end
      applyStimulus(ce, cw, cr, pick_addr(), 4'($urandom), $urandom,
                    pb_valid, pb_we, pb_addr, pb_be, pb_wd);
      if (exp_gnt_last) pb_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
